// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_rx_state_t      receiver FSM states
//   DEFAULT_CLK_PER_BIT  clocks per bit at 100 MHz / 115200 baud (shared with the transmitter)
//   majority3            2-of-3 vote used to reject single-cycle noise on the line
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int DEFAULT_CLK_PER_BIT = 868;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clock  in  system clock
//   reset  in  synchronous, active-high; both flops load RESET_VALUE
//   d      in  asynchronous input
//   q      out input resolved into the clock domain (2-cycle latency)
module bit_sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops are written with <= so every register samples the value from
  // before the edge; blocking here would collapse the two stages into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver, LSB first, idle-high line.
//   clock      in  system clock, all state on posedge
//   reset      in  synchronous, active-high
//   rxd        in  asynchronous serial input
//   rx_ready   out 1-cycle strobe, rdata holds a newly received good byte
//   rdata      out last good byte, stable until the next rx_ready
//   frame_err  out 1-cycle strobe, stop bit sampled low
//   busy       out high whenever the FSM is not idle
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_ready,
  output logic [7:0] rdata,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] SAMPLE_POINT = CNT_W'(CLK_PER_BIT / 2);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLK_PER_BIT - 1);

  logic           rs;
  logic [2:0]     hist;
  logic           maj;
  uart_rx_state_t state, state_next;
  logic [CNT_W-1:0] counter, counter_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shift, shift_next;
  logic [7:0]     rdata_next;
  logic           rx_ready_next, frame_err_next;

  // Synchronizer resets to 1 so a reset never looks like a start edge.
  bit_sync_2ff #(.RESET_VALUE(1'b1)) u_rxd_sync (
    .clock (clock),
    .reset (reset),
    .d     (rxd),
    .q     (rs)
  );

  // hist[0] is rs one cycle ago, which doubles as the edge-detect history.
  assign maj  = majority3(hist);
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      hist      <= 3'b111;
      state     <= IDLE;
      counter   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rdata     <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      hist      <= {hist[1:0], rs};
      state     <= state_next;
      counter   <= counter_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      rdata     <= rdata_next;
      rx_ready  <= rx_ready_next;
      frame_err <= frame_err_next;
    end
  end

  // START centres the counter on the middle of the start bit; from then on
  // DATA and STOP sample at the counter wrap, one full bit period apart.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_next     = state;
    counter_next   = counter + CNT_W'(1);
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    rdata_next     = rdata;
    rx_ready_next  = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      IDLE: begin
        counter_next = '0;
        if (!rs && hist[0]) state_next = START;
      end

      START: begin
        if (counter == SAMPLE_POINT) begin
          counter_next = '0;
          bit_idx_next = '0;
          state_next   = maj ? IDLE : DATA;
        end
      end

      DATA: begin
        if (counter == BIT_LAST) begin
          counter_next = '0;
          shift_next   = {maj, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end

      STOP: begin
        if (counter == BIT_LAST) begin
          counter_next = '0;
          if (maj) begin
            rdata_next    = shift;
            rx_ready_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end

      BREAK: begin
        // Hold off until the line is released so a stuck-low pin is not
        // decoded as a stream of 0x00 frames.
        counter_next = '0;
        if (rs) state_next = IDLE;
      end

      default: begin
        counter_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench: instance a runs at 16 clocks/bit, instance b at 868
// clocks/bit with +/-3% sender skew, both driven concurrently.
module tb_uart_byte_receiver;

  localparam int CPB_A = 16;
  localparam int CPB_B = 868;

  logic       clock;
  logic       reset_a, reset_b;
  logic       rxd_a, rxd_b;
  logic       rx_ready_a, rx_ready_b;
  logic [7:0] rdata_a, rdata_b;
  logic       frame_err_a, frame_err_b;
  logic       busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  uart_byte_receiver #(.CLK_PER_BIT(CPB_A), .CNT_W(16)) dut_a (
    .clock     (clock),
    .reset     (reset_a),
    .rxd       (rxd_a),
    .rx_ready  (rx_ready_a),
    .rdata     (rdata_a),
    .frame_err (frame_err_a),
    .busy      (busy_a)
  );

  uart_byte_receiver #(.CLK_PER_BIT(CPB_B), .CNT_W(16)) dut_b (
    .clock     (clock),
    .reset     (reset_b),
    .rxd       (rxd_b),
    .rx_ready  (rx_ready_b),
    .rdata     (rdata_b),
    .frame_err (frame_err_b),
    .busy      (busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- strobe monitors (sampled on negedge) ----------------
  logic [7:0] rx_q_a[$];
  time        rx_t_a[$];
  logic [7:0] rx_q_b[$];
  int ferr_a = 0, ferr_b = 0;
  int overlap = 0, repeats = 0;

  initial begin
    logic prev_a, prev_b;
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge clock);
      if (rx_ready_a) begin rx_q_a.push_back(rdata_a); rx_t_a.push_back($time); end
      if (rx_ready_b) rx_q_b.push_back(rdata_b);
      if (frame_err_a) ferr_a++;
      if (frame_err_b) ferr_b++;
      if ((rx_ready_a && frame_err_a) || (rx_ready_b && frame_err_b)) overlap++;
      if ((prev_a && (rx_ready_a || frame_err_a)) || (prev_b && (rx_ready_b || frame_err_b)))
        repeats++;
      prev_a = rx_ready_a || frame_err_a;
      prev_b = rx_ready_b || frame_err_b;
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  time t_start_a;

  task automatic wait_a(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte_a(input logic [7:0] data, input logic stop);
    t_start_a = $time;
    rxd_a = 1'b0;
    wait_a(CPB_A);
    for (int i = 0; i < 8; i++) begin
      rxd_a = data[i];
      wait_a(CPB_A);
    end
    rxd_a = stop;
    wait_a(CPB_A);
  endtask

  task automatic send_byte_b(input logic [7:0] data, input int period);
    rxd_b = 1'b0;
    repeat (period) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd_b = data[i];
      repeat (period) @(negedge clock);
    end
    rxd_b = 1'b1;
    repeat (period) @(negedge clock);
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (i < rx_q_a.size()) ? {24'h0, rx_q_a[i]} : 32'hDEAD_BEEF;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [7:0] b2b [5] = '{8'h99, 8'h04, 8'h00, 8'h00, 8'hAA};
  logic [7:0] skew_bytes [6] = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E};
  int         skew_period [6] = '{894, 842, 894, 842, 894, 842};

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    rxd_a   = 1'b1;
    rxd_b   = 1'b1;
    repeat (5) @(negedge clock);

    check("reset_rx_ready", {31'h0, rx_ready_a}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err_a}, 32'h0);
    check("reset_rdata", {24'h0, rdata_a}, 32'h00);
    check("reset_busy", {31'h0, busy_a}, 32'h0);

    reset_a = 1'b0;
    reset_b = 1'b0;
    wait_a(10);

    fork
      begin : path_a
        // 1. single frame 0x55 and strobe latency
        rx_q_a.delete(); rx_t_a.delete();
        send_byte_a(8'h55, 1'b1);
        wait_a(40);
        check("t1_count", rx_q_a.size(), 1);
        check("t1_data", q_at(0), 32'h55);
        check("t1_latency",
              (rx_t_a.size() > 0) ? 32'((rx_t_a[0] - t_start_a) / 10) : 32'hFFFF_FFFF,
              CPB_A / 2 + 9 * CPB_A + 4);
        check("t1_busy_idle", {31'h0, busy_a}, 32'h0);

        // 2. back-to-back frames
        rx_q_a.delete();
        foreach (b2b[i]) send_byte_a(b2b[i], 1'b1);
        wait_a(40);
        check("t2_count", rx_q_a.size(), 5);
        foreach (b2b[i]) check($sformatf("t2_byte%0d", i), q_at(i), {24'h0, b2b[i]});
        check("t2_ferr", ferr_a, 0);

        // 3. short glitch is a false start
        rx_q_a.delete();
        rxd_a = 1'b0;
        wait_a(3);
        rxd_a = 1'b1;
        begin
          logic idle_seen;
          idle_seen = 1'b0;
          for (int i = 0; i < 10 && !idle_seen; i++) begin
            wait_a(1);
            if (!busy_a) idle_seen = 1'b1;
          end
          check("t3_busy_low_in_10", {31'h0, idle_seen}, 32'h1);
        end
        wait_a(40);
        check("t3_no_ready", rx_q_a.size(), 0);
        check("t3_no_ferr", ferr_a, 0);

        // 4. bad stop bit, line held low, then recovery
        send_byte_a(8'hA3, 1'b0);
        wait_a(40);
        check("t4_ferr", ferr_a, 1);
        check("t4_no_ready", rx_q_a.size(), 0);
        check("t4_rdata_kept", {24'h0, rdata_a}, 32'hAA);
        check("t4_busy_in_break", {31'h0, busy_a}, 32'h1);
        rxd_a = 1'b1;
        wait_a(2 * CPB_A);
        send_byte_a(8'h3C, 1'b1);
        wait_a(40);
        check("t4_recover_count", rx_q_a.size(), 1);
        check("t4_recover_data", {24'h0, rdata_a}, 32'h3C);
        check("t4_ferr_total", ferr_a, 1);

        // 5. reset mid-frame during data bit 4 of 0xFF
        rx_q_a.delete();
        rxd_a = 1'b0;
        wait_a(CPB_A);
        rxd_a = 1'b1;
        wait_a(4 * CPB_A + CPB_A / 2);
        reset_a = 1'b1;
        wait_a(2);
        reset_a = 1'b0;
        wait_a(8 * CPB_A);
        check("t5_no_ready", rx_q_a.size(), 0);
        check("t5_no_ferr", ferr_a, 1);
        check("t5_rdata_reset", {24'h0, rdata_a}, 32'h00);
        send_byte_a(8'h12, 1'b1);
        wait_a(40);
        check("t5_next_count", rx_q_a.size(), 1);
        check("t5_next_data", {24'h0, rdata_a}, 32'h12);
      end

      begin : path_b
        // 6. full-rate divider with +/-3% sender skew
        foreach (skew_bytes[i]) begin
          send_byte_b(skew_bytes[i], skew_period[i]);
          repeat (20) @(negedge clock);
        end
        repeat (CPB_B) @(negedge clock);
      end
    join

    check("t6_count", rx_q_b.size(), 6);
    foreach (skew_bytes[i])
      check($sformatf("t6_byte%0d", i),
            (i < rx_q_b.size()) ? {24'h0, rx_q_b[i]} : 32'hDEAD_BEEF,
            {24'h0, skew_bytes[i]});
    check("t6_ferr", ferr_b, 0);

    check("strobe_overlap", overlap, 0);
    check("strobe_repeat", repeats, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
